// File: rtl/led_on.sv
// Power-on LED driver: dark for STARTUP_CYCLES after reset, then PWM at DUTY/2^PWM_BITS.
// Optional blink gating is compiled in with LED_ON_BLINK_EN.
module led_on #(
  parameter int STARTUP_CYCLES    = 100,
  parameter int PWM_BITS          = 8,
  parameter int DUTY              = 256,
  parameter int BLINK_HALF_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic out
);

  if (DUTY < 0 || DUTY > (1 << PWM_BITS) || PWM_BITS < 1 || PWM_BITS > 16 ||
      STARTUP_CYCLES < 0 || STARTUP_CYCLES > 24'hFF_FFFF || BLINK_HALF_CYCLES < 1) begin : g_bad_param
    $error("led_on: parameter out of range");
  end

  localparam logic [23:0]       StartupW = 24'(STARTUP_CYCLES);
  localparam logic [PWM_BITS:0] DutyW    = (PWM_BITS + 1)'(DUTY);

  typedef enum logic [1:0] {S_RESET, S_WAIT, S_ON} state_e;

  state_e              state_q;
  logic [23:0]         dly_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic [PWM_BITS-1:0] pwm_idx;
  logic [PWM_BITS-1:0] pwm_d;
  logic                pwm_hit;
  logic                lit_d;
  logic                out_q;

  // The entry edge into S_ON already drives PWM slot 0, so the index is forced
  // to zero outside S_ON and the register then holds the next slot to emit.
  always_comb begin
    pwm_idx = (state_q == S_ON) ? pwm_q : '0;
    pwm_d   = pwm_idx + PWM_BITS'(1);
    pwm_hit = {1'b0, pwm_idx} < DutyW;
  end

`ifdef LED_ON_BLINK_EN
  localparam int              BlinkW = $clog2(BLINK_HALF_CYCLES + 1);
  localparam logic [BlinkW-1:0] HalfW = BlinkW'(BLINK_HALF_CYCLES);

  logic [BlinkW-1:0] bcnt_q, bcnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    phase_d = 1'b1;
    bcnt_d  = BlinkW'(1);
    if (state_q == S_ON) begin
      if (bcnt_q == HalfW) begin
        phase_d = ~phase_q;
        bcnt_d  = BlinkW'(1);
      end else begin
        phase_d = phase_q;
        bcnt_d  = bcnt_q + BlinkW'(1);
      end
    end
    lit_d = pwm_hit & phase_d;
  end
`else
  always_comb lit_d = pwm_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      dly_q   <= '0;
      pwm_q   <= '0;
      out_q   <= 1'b0;
`ifdef LED_ON_BLINK_EN
      bcnt_q  <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_RESET, S_WAIT: begin
          // dly_q is zero in S_RESET, so STARTUP_CYCLES = 0 skips S_WAIT entirely.
          if (dly_q == StartupW) begin
            state_q <= S_ON;
            pwm_q   <= pwm_d;
            out_q   <= lit_d;
`ifdef LED_ON_BLINK_EN
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
`endif
          end else begin
            state_q <= S_WAIT;
            dly_q   <= dly_q + 24'd1;
            out_q   <= 1'b0;
          end
        end
        S_ON: begin
          pwm_q   <= pwm_d;
          out_q   <= lit_d;
`ifdef LED_ON_BLINK_EN
          bcnt_q  <= bcnt_d;
          phase_q <= phase_d;
`endif
        end
        default: begin
          state_q <= S_RESET;
          out_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_led_on.sv
// Directed bench for led_on: several parameterisations share one clock and reset,
// each compared edge by edge against hand-derived expected waveforms.
module tb_led_on;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_def, out_s0, out_pwm, out_d0, out_full, out_blk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  led_on u_def (.clk(clk), .rst(rst), .out(out_def));
  led_on #(.STARTUP_CYCLES(0)) u_s0 (.clk(clk), .rst(rst), .out(out_s0));
  led_on #(.STARTUP_CYCLES(3), .PWM_BITS(4), .DUTY(5)) u_pwm (.clk(clk), .rst(rst), .out(out_pwm));
  led_on #(.STARTUP_CYCLES(3), .PWM_BITS(4), .DUTY(0)) u_d0 (.clk(clk), .rst(rst), .out(out_d0));
  led_on #(.STARTUP_CYCLES(2), .PWM_BITS(4), .DUTY(16)) u_full (.clk(clk), .rst(rst), .out(out_full));
  led_on #(.STARTUP_CYCLES(3), .BLINK_HALF_CYCLES(8)) u_blk (.clk(clk), .rst(rst), .out(out_blk));

  task automatic check(input string tag, input int e, input logic got, input logic exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected waveforms, e = edge number counted from the last edge with rst sampled high.
  function automatic logic exp_blk(input int e);
    if (e <= 3) return 1'b0;
`ifdef LED_ON_BLINK_EN
    return (((e - 4) / 8) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_all(input int e);
    check("default", e, out_def,  (e <= 100) ? 1'b0 : 1'b1);
    check("start0",  e, out_s0,   (e >= 1) ? 1'b1 : 1'b0);
    check("pwm4d5",  e, out_pwm,  (e <= 3) ? 1'b0 : (((e - 4) % 16) < 5));
    check("duty0",   e, out_d0,   1'b0);
    check("dutyfull", e, out_full, (e <= 2) ? 1'b0 : 1'b1);
    check("blink8",  e, out_blk,  exp_blk(e));
  endtask

  initial begin
    rst = 1'b1;
    repeat (10) tick();
    check_all(0);

    rst = 1'b0;
    for (int e = 1; e <= 1100; e++) begin
      tick();
      check_all(e);
    end

    // One-cycle reset while every instance is in S_ON restarts the start-up delay.
    rst = 1'b1;
    tick();
    check_all(0);
    rst = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      check_all(e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
